// File: rtl/fib_pkg.sv
// Shared types and constants for the two-requester Fibonacci scheduler.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 8;
  localparam int unsigned FIB_IDX_W = 5;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } fib_state_e;

  // Round-robin pick: on a tie, favour the requester not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/fib_core.sv
// a/b Fibonacci recurrence with sticky overflow tracking for each term.
module fib_core
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a,
  output logic             ovf_a
);

  logic [WIDTH-1:0] b;
  logic             ovf_b;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a     <= '0;
      b     <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (load) begin
      a     <= '0;
      b     <= WIDTH'(1);
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (step) begin
      a     <= b;
      b     <= sum[WIDTH-1:0];
      ovf_a <= ovf_b;
      ovf_b <= ovf_b | sum[WIDTH] | ovf_a;
    end
  end

endmodule

// File: rtl/fib_scheduler.sv
// Round-robin shared Fibonacci datapath; steps the recurrence on a decimated tick of clk.
module fib_scheduler
  import fib_pkg::*;
#(
  parameter int unsigned DECIMATION = 16,
  parameter int unsigned WIDTH      = FIB_WIDTH,
  parameter int unsigned IDX_W      = FIB_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [IDX_W-1:0] idx0,
  input  logic [IDX_W-1:0] idx1,
  output logic [1:0]       ack,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned TW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DECIMATION - 1);

  fib_state_e       state;
  logic             last;
  logic             owner;
  logic             grant;
  logic [IDX_W-1:0] cnt;
  logic [TW-1:0]    tick;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] core_a;
  logic             core_ovf;

  always_comb begin
    grant     = rr_pick(req, last);
    core_load = (state == ST_LOAD);
    core_step = (state == ST_RUN) && (cnt != '0) && (tick == TICK_MAX);
  end

  fib_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .step  (core_step),
    .a     (core_a),
    .ovf_a (core_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      ack    <= '0;
      done   <= '0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      last   <= REQ1;
      owner  <= REQ0;
      cnt    <= '0;
      tick   <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            owner      <= grant;
            cnt        <= grant ? idx1 : idx0;
            ack[grant] <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tick  <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          // done is raised on entry to DONE so it lands idx*DECIMATION+2 after ack
          if (cnt == '0) begin
            done[owner] <= 1'b1;
            result      <= core_a;
            ovf         <= core_ovf;
            last        <= owner;
            state       <= ST_DONE;
          end else begin
            tick <= (tick == TICK_MAX) ? '0 : tick + TW'(1);
            if (tick == TICK_MAX) cnt <= cnt - IDX_W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_scheduler.sv
// Directed bench: unit 0 runs at DECIMATION=1, unit 1 at DECIMATION=16, sharing clk and reset.
module tb_fib_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_v  [2];
  logic [4:0] idx0_v [2];
  logic [4:0] idx1_v [2];
  logic [1:0] ack_v  [2];
  logic [1:0] done_v [2];
  logic [7:0] res_v  [2];
  logic       ovf_v  [2];
  logic       busy_v [2];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fib_scheduler #(.DECIMATION(1), .WIDTH(8), .IDX_W(5)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .idx0(idx0_v[0]), .idx1(idx1_v[0]),
    .ack(ack_v[0]), .done(done_v[0]), .result(res_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0])
  );

  fib_scheduler #(.DECIMATION(16), .WIDTH(8), .IDX_W(5)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .idx0(idx0_v[1]), .idx1(idx1_v[1]),
    .ack(ack_v[1]), .done(done_v[1]), .result(res_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1])
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check_vec({tag, " ack"},    32'(ack_v[u]),  0);
    check_vec({tag, " done"},   32'(done_v[u]), 0);
    check_vec({tag, " result"}, 32'(res_v[u]),  0);
    check_vec({tag, " ovf"},    32'(ovf_v[u]),  0);
    check_vec({tag, " busy"},   32'(busy_v[u]), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_v[0] = '0;
    req_v[1] = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for an ack pulse, then checks which requester got it.
  task automatic wait_ack(input int u, input logic [1:0] exp, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_v[u] != 2'b00) break;
    end
    check_vec({tag, " ack"},  32'(ack_v[u]),  32'(exp));
    check_vec({tag, " busy"}, 32'(busy_v[u]), 1);
  endtask

  task automatic wait_done(input int u, input logic [1:0] exp_done, input int exp_lat,
                           input logic [7:0] exp_res, input logic exp_ovf, input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      lat++;
      if (done_v[u] != 2'b00) break;
    end
    check_vec({tag, " done"},    32'(done_v[u]), 32'(exp_done));
    check_vec({tag, " latency"}, 32'(lat),       32'(exp_lat));
    check_vec({tag, " result"},  32'(res_v[u]),  32'(exp_res));
    check_vec({tag, " ovf"},     32'(ovf_v[u]),  32'(exp_ovf));
    check_vec({tag, " no ack"},  32'(ack_v[u]),  0);
  endtask

  task automatic single(input int u, input int who, input logic [4:0] idx, input int lat,
                        input logic [7:0] res, input logic ov, input string tag);
    logic [1:0] bitv;
    bitv = (who == 0) ? 2'b01 : 2'b10;
    if (who == 0) idx0_v[u] = idx; else idx1_v[u] = idx;
    req_v[u] = bitv;
    wait_ack(u, bitv, tag);
    req_v[u] = 2'b00;
    wait_done(u, bitv, lat, res, ov, tag);
  endtask

  initial begin
    int seen_done;
    for (int u = 0; u < 2; u++) begin
      req_v[u] = '0; idx0_v[u] = '0; idx1_v[u] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle(0, "reset u0");
    check_idle(1, "reset u1");
    reset = 1'b0;
    @(negedge clk);

    // DECIMATION=1 basic, overflow and edge indices
    single(0, 0, 5'd13, 15, 8'd233, 1'b0, "f13");
    @(negedge clk);
    check_vec("f13 busy after", 32'(busy_v[0]), 0);
    check_vec("f13 result hold", 32'(res_v[0]), 233);
    single(0, 0, 5'd14, 16, 8'd121, 1'b1, "f14");
    single(0, 1, 5'd31, 33, 8'd221, 1'b1, "f31");
    single(0, 0, 5'd0,  2,  8'd0,   1'b0, "f0");
    single(0, 1, 5'd1,  3,  8'd1,   1'b0, "f1");
    single(0, 0, 5'd2,  4,  8'd1,   1'b0, "f2");

    // Arbitration from reset: 0 wins first tie, then 1, then 0 again
    do_reset();
    idx0_v[0] = 5'd12;
    idx1_v[0] = 5'd10;
    req_v[0] = 2'b11;
    wait_ack(0, 2'b01, "tie1");
    req_v[0] = 2'b10;
    wait_done(0, 2'b01, 14, 8'd144, 1'b0, "tie1");
    wait_ack(0, 2'b10, "tie1 second");
    req_v[0] = 2'b00;
    wait_done(0, 2'b10, 12, 8'd55, 1'b0, "tie1 second");
    @(negedge clk);
    req_v[0] = 2'b11;
    wait_ack(0, 2'b01, "tie2");
    req_v[0] = 2'b00;
    wait_done(0, 2'b01, 14, 8'd144, 1'b0, "tie2");

    // DECIMATION=16 timing
    single(1, 0, 5'd0, 2,  8'd0, 1'b0, "d16 f0");
    single(1, 1, 5'd5, 82, 8'd5, 1'b0, "d16 f5");

    // Reset in the middle of RUN kills the request without a done pulse
    idx0_v[1] = 5'd7;
    req_v[1] = 2'b01;
    wait_ack(1, 2'b01, "kill");
    req_v[1] = 2'b00;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle(1, "kill async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done_v[1] != 2'b00) seen_done++;
    end
    check_vec("kill no done", 32'(seen_done), 0);
    single(1, 0, 5'd2, 34, 8'd1, 1'b0, "after kill");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
